fifo_read_streamer: RTL and testbench
=====================================

FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width of FIFO read data and stream data.
REQ-002 Parameter PKT_LEN, default 16, beats per packet; legal range 1..65535.
REQ-003 rclk  input  1  single clock; all logic on rising edge.
REQ-004 rrst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  1  FIFO read-side empty flag, synchronous to rclk.
REQ-006 fifo_dout  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_ren is sampled high.
REQ-007 fifo_ren  output  1  FIFO read enable; one word is popped per cycle sampled high.
REQ-008 m_valid  output  1  stream data valid.
REQ-009 m_ready  input  1  downstream accept; a beat transfers when m_valid and m_ready are both high at a rising edge.
REQ-010 m_data  output  DATA_WIDTH  stream data, head of the internal buffer.
REQ-011 m_last  output  1  high on the final beat of each PKT_LEN-beat packet.
REQ-012 m_parity  output  1  even parity of m_data; present only per REQ-030.

Function
REQ-013 The block SHALL hold a 2-entry internal buffer (occupancy occ, 0..2) plus one in-flight flag (inflight) marking a FIFO read issued in the previous cycle.
REQ-014 fifo_ren SHALL be combinational: high iff !fifo_empty && !rrst && (occ + inflight - pop) < 2, where pop = m_valid && m_ready this cycle.
REQ-015 inflight SHALL register fifo_ren; when inflight is high, fifo_dout SHALL be written into the buffer tail on that edge.
REQ-016 Simultaneous write (inflight) and pop in one cycle SHALL leave occ unchanged and preserve word order.
REQ-017 The buffer SHALL never overflow; occ + inflight SHALL never exceed 2.
REQ-018 m_valid SHALL equal (occ != 0); m_data SHALL be the oldest buffered word; m_valid and m_data SHALL be stable while m_valid && !m_ready.
REQ-019 Latency: first word SHALL appear on m_valid 2 cycles after fifo_empty drops, with the buffer empty and m_ready irrelevant.
REQ-020 Throughput: with fifo_empty low and m_ready held high, one beat per cycle SHALL be sustained after the initial latency.
REQ-021 Beat counter bcnt (width ceil(log2(PKT_LEN)), minimum 1) SHALL increment on each transfer and wrap to 0 after PKT_LEN-1.
REQ-022 m_last SHALL equal m_valid && (bcnt == PKT_LEN-1); for PKT_LEN=1, every beat is last.
REQ-023 Removing m_ready mid-packet SHALL neither drop nor duplicate words, and SHALL not alter bcnt.
REQ-024 fifo_empty rising while a read is in flight SHALL not lose the in-flight word.

Reset
REQ-025 Asserting rrst SHALL asynchronously clear occ, inflight, bcnt and buffer pointers.
REQ-026 During reset: fifo_ren=0, m_valid=0, m_last=0, m_data=0, m_parity=0.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight words; the in-flight FIFO word is lost by design.
REQ-028 Following release of rrst, the first fifo_ren SHALL be issued no earlier than the first rising edge with rrst low.

Configuration
REQ-029 Macro RD_STREAM_PARITY_EN SHALL control parity generation.
REQ-030 With RD_STREAM_PARITY_EN defined: m_parity port exists and equals ^m_data (XOR reduction), 0 when m_valid=0. Without it: port and logic are absent; all other behaviour is identical.

Verification
REQ-031 FIFO preloaded with 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 on three consecutive cycles, first 2 cycles after fifo_empty falls; fifo_ren never high while fifo_empty=1.
REQ-032 m_ready=0, FIFO nonempty -> exactly 2 fifo_ren pulses, occ=2, m_data holds first word; raise m_ready -> words in order, no loss.
REQ-033 PKT_LEN=4, 10 words streamed -> m_last high on beats 4 and 8 only; bcnt=2 at end.
REQ-034 m_ready toggling 1,0,1,0 with fifo_empty toggling alternately -> output sequence equals FIFO sequence, no duplicates, occ+inflight <= 2 every cycle (assertion).
REQ-035 rrst pulsed asynchronously (mid-cycle) with occ=2 and inflight=1 -> outputs zero immediately; after release, next streamed word is the next FIFO word, bcnt restarts at 0.
REQ-036 RD_STREAM_PARITY_EN defined, m_data=0x07 -> m_parity=1; m_data=0x03 -> m_parity=0.

Source files
------------

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: pulls words from a registered-output FIFO read port and streams them out with packet framing.
// Latency: first beat valid 2 cycles after fifo_empty falls; sustains one beat per cycle afterwards.
// Backpressure: m_ready low holds the head beat; FIFO reads stop once buffered + in-flight words reach 2.
// Optional feature: define RD_STREAM_PARITY_EN to add the m_parity output (even parity of m_data).
module fifo_read_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef RD_STREAM_PARITY_EN
    ,
    output logic                  m_parity
`endif
);
    localparam int            BW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] BCNT_MAX = BW'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  inflight_q;
    logic [1:0]            occ_q, occ_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  pop;

    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid & m_ready;

    // occ + inflight never exceeds 2 and pop needs occ >= 1, so 2 bits hold the exact result
    assign occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    // A new read is allowed only if its word will have a free slot when it lands next cycle
    assign fifo_ren = !fifo_empty && !rrst && (occ_d != 2'd2);

    assign m_data = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_last = m_valid && (bcnt_q == BCNT_MAX);

`ifdef RD_STREAM_PARITY_EN
    assign m_parity = ^m_data;
`endif

    // Pointer and beat-counter next state; the counter only moves on an accepted beat
    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ inflight_q;
        bcnt_d   = bcnt_q;
        if (pop) begin
            bcnt_d = (bcnt_q == BCNT_MAX) ? '0 : bcnt_q + BW'(1);
        end
    end

    // Control state: occupancy, pointers, in-flight read marker and beat counter
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            occ_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            bcnt_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= fifo_ren;
            bcnt_q     <= bcnt_d;
        end
    end

    // Buffer storage: the word requested last cycle is written at the tail
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (inflight_q) begin
            mem_q[wr_ptr_q] <= fifo_dout;
        end
    end
endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: FIFO model plus in-order scoreboard, PKT_LEN=4.
module tb_fifo_read_streamer;
    localparam int DW = 8;
    localparam int PL = 4;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_ren;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef RD_STREAM_PARITY_EN
    logic          m_parity;
`endif

    always #5 rclk = ~rclk;

    fifo_read_streamer #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_ren   (fifo_ren),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef RD_STREAM_PARITY_EN
        ,
        .m_parity   (m_parity)
`endif
    );

    typedef struct {
        int nwords;
        int rdy_pct;
        int av_pct;
        int exp_lasts;
        int exp_bcnt;
        int exp_span;
    } row_t;

    int            n_chk;
    int            n_fail;
    logic [DW-1:0] src_q[$];   // words still inside the FIFO
    logic [DW-1:0] exp_q[$];   // words popped from the FIFO, owed to the stream
    logic          samp_v[$];
    logic [DW-1:0] samp_d[$];
    bit            gate;       // forces the FIFO to look empty
    int            beats, lasts, ren_cnt, cyc, first_cyc, last_cyc;
    logic [DW-1:0] first_data, data_s, prev_data;
    bit            prev_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_empty();
        fifo_empty = gate || (src_q.size() == 0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        beats      = 0;
        lasts      = 0;
        prev_stall = 0;
    endtask

    // One clock: check outputs at the falling edge, then update the FIFO model after the rising edge
    task automatic cycle();
        logic          ren_s;
        logic [DW-1:0] w;
        @(negedge rclk);
        ren_s  = fifo_ren;
        data_s = m_data;
        samp_v.push_back(m_valid);
        samp_d.push_back(m_data);
        if (fifo_empty) check("ren_while_empty", fifo_ren, 0);
        check("occ_bound", (dut.occ_q + dut.inflight_q) > 2, 0);
        if (rrst) begin
            check("rst_ren", fifo_ren, 0);
            check("rst_valid", m_valid, 0);
            check("rst_data", m_data, 0);
            check("rst_last", m_last, 0);
        end
        if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", m_data, 'x);
            end else begin
                w = exp_q.pop_front();
                check("beat_data", m_data, w);
                check("beat_last", m_last, (beats % PL) == PL - 1);
`ifdef RD_STREAM_PARITY_EN
                check("beat_parity", m_parity, ^w);
`endif
            end
            if (beats == 0) begin
                first_data = m_data;
                first_cyc  = cyc;
            end
            last_cyc = cyc;
            beats++;
            if (m_last) lasts++;
        end else if (!m_valid) begin
            check("idle_last", m_last, 0);
`ifdef RD_STREAM_PARITY_EN
            check("idle_parity", m_parity, 0);
`endif
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (ren_s) ren_cnt++;
        cyc++;
        @(posedge rclk);
        #1;
        if (ren_s && src_q.size() > 0) begin
            fifo_dout = src_q.pop_front();
            exp_q.push_back(fifo_dout);
        end
        drive_empty();
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        clear_model();
        drive_empty();
        cycle();
        cycle();
        rrst = 1'b0;
        clear_model();
    endtask

    task automatic run_rand(input int target, input int rdy_pct, input int av_pct, input int budget);
        int k;
        k = 0;
        while (beats < target && k < budget) begin
            m_ready = ($urandom_range(99) < rdy_pct);
            gate    = ($urandom_range(99) >= av_pct);
            drive_empty();
            cycle();
            k++;
        end
        check("stream_complete", beats, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t          tbl[6];
        int            first;
        logic [DW-1:0] nxt;
        tbl[0] = '{10, 100, 100, 2, 2, 9};
        tbl[1] = '{ 7,  50,  70, 1, 3, -1};
        tbl[2] = '{13,  30,  50, 3, 1, -1};
        tbl[3] = '{ 4,  80,  40, 1, 0, -1};
        tbl[4] = '{ 1, 100, 100, 0, 1, 0};
        tbl[5] = '{ 8,  60,  60, 2, 0, -1};
        n_chk = 0; n_fail = 0; cyc = 0; ren_cnt = 0;
        rrst = 1'b1; m_ready = 1'b0; fifo_dout = '0; gate = 1'b1;
        fifo_empty = 1'b1;
        #1;
        do_reset();

        // Preloaded 11,22,33 held behind an empty flag, then released
        src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
        gate = 1'b1; m_ready = 1'b1;
        do_reset();
        repeat (3) cycle();
        gate = 1'b0;
        drive_empty();
        samp_v.delete(); samp_d.delete();
        for (int i = 0; i < 8; i++) cycle();
        first = -1;
        for (int i = 7; i >= 0; i--) if (samp_v[i]) first = i;
        check("first_latency", first, 2);
        check("seq_d0", samp_d[2], 8'h11);
        check("seq_d1", samp_d[3], 8'h22);
        check("seq_d2", samp_d[4], 8'h33);
        check("seq_v1", samp_v[3], 1);
        check("seq_v2", samp_v[4], 1);
        check("seq_end", samp_v[5], 0);

        // Stalled sink: exactly two reads, head held, then drained in order
        for (int i = 0; i < 5; i++) src_q.push_back(8'hA0 + 8'(i));
        m_ready = 1'b0; gate = 1'b0;
        do_reset();
        ren_cnt = 0;
        repeat (8) cycle();
        check("stall_ren_cnt", ren_cnt, 2);
        check("stall_occ", dut.occ_q, 2);
        check("stall_head", data_s, 8'hA0);
        m_ready = 1'b1;
        for (int k = 0; k < 40 && beats < 5; k++) cycle();
        check("stall_drain", beats, 5);

        // Ready and availability toggling in alternation
        for (int i = 0; i < 8; i++) src_q.push_back(8'h50 + 8'(i));
        gate = 1'b0;
        do_reset();
        for (int i = 0; i < 100 && beats < 8; i++) begin
            m_ready = (i % 2 == 0);
            gate    = (i % 2 == 1);
            drive_empty();
            cycle();
        end
        check("toggle_beats", beats, 8);
        check("toggle_leftover", exp_q.size(), 0);

        // Table-driven packet scenarios, each from a fresh reset
        foreach (tbl[r]) begin
            src_q.delete();
            for (int i = 0; i < tbl[r].nwords; i++) src_q.push_back(8'($urandom));
            gate = 1'b0; m_ready = 1'b0;
            do_reset();
            run_rand(tbl[r].nwords, tbl[r].rdy_pct, tbl[r].av_pct, 600);
            check("tbl_lasts", lasts, tbl[r].exp_lasts);
            check("tbl_bcnt", dut.bcnt_q, tbl[r].exp_bcnt);
            if (tbl[r].exp_span >= 0) check("tbl_span", last_cyc - first_cyc, tbl[r].exp_span);
        end

        // Random stress with refills, then drain
        src_q.delete();
        gate = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (src_q.size() < 6 && $urandom_range(3) == 0) src_q.push_back(8'($urandom));
            m_ready = ($urandom_range(99) < 60);
            gate    = ($urandom_range(99) < 30);
            drive_empty();
            cycle();
        end
        gate = 1'b0; m_ready = 1'b1;
        drive_empty();
        for (int k = 0; k < 100 && (src_q.size() + exp_q.size()) > 0; k++) cycle();
        check("stress_drained", src_q.size() + exp_q.size(), 0);

        // Asynchronous mid-cycle reset with the buffer pipeline full
        src_q.delete();
        for (int i = 0; i < 10; i++) src_q.push_back(8'h80 + 8'(i));
        gate = 1'b0; m_ready = 1'b1;
        do_reset();
        repeat (5) cycle();
        check("pre_rst_fill", dut.occ_q + dut.inflight_q, 2);
        #3;
        rrst = 1'b1;
        #1;
        check("async_valid", m_valid, 0);
        check("async_data", m_data, 0);
        check("async_last", m_last, 0);
        check("async_ren", fifo_ren, 0);
        clear_model();
        nxt = src_q[0];
        cycle();
        check("async_bcnt", dut.bcnt_q, 0);
        rrst = 1'b0;
        for (int k = 0; k < 20 && beats < 1; k++) cycle();
        check("post_rst_beat", beats, 1);
        check("post_rst_word", first_data, nxt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
